// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: one SLICE-bit chunk of the selected op per clock,
// start/busy/done handshake, registered result and zero flag.

module logic_slice #(
  parameter int SLICE = 8
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: y = a ^ b;
      3'b011: y = ~(a | b);
      3'b100: y = a & ~b;
      3'b101: y = a | ~b;
      3'b110: y = a;
      3'b111: y = ~a;
      default: y = '0;
    endcase
  end
endmodule

module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  // WIDTH must be a multiple of SLICE.
  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state;
  logic [NSL-1:0][SLICE-1:0]     a_q, b_q, acc, acc_nxt;
  logic [2:0]                    op_q;
  logic [CW-1:0]                 cnt;
  logic [SLICE-1:0]              sl_y;
  logic                          last;

  // One shared slice datapath; the operand chunk is muxed by the slice counter.
  logic_slice #(.SLICE(SLICE)) u_slice (
    .op (op_q),
    .a  (a_q[cnt]),
    .b  (b_q[cnt]),
    .y  (sl_y)
  );

  assign last = (cnt == CW'(NSL - 1));

  always_comb begin
    acc_nxt      = acc;
    acc_nxt[cnt] = sl_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (last) begin
            // Completion folds in the final slice so result never shows a partial word.
            result <= acc_nxt;
            zero   <= (acc_nxt == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
